// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//
// Purpose
//   Shares one synchronous data memory between two requesters: port 0 (core)
//   and port 1 (loader/DMA). Only one transaction is in flight at a time. The
//   controller steps through IDLE -> ISSUE (-> WAIT for reads) -> IDLE.
//
// Handshake
//   A requester raises reqN with weN/addrN/wdataN and holds them stable until
//   it sees gntN. The request is sampled and latched in IDLE. gntN pulses for
//   one cycle in ISSUE, which is the cycle the memory strobe is driven. Once
//   latched, the transaction completes even if reqN drops. A read returns
//   rvalidN for one cycle in WAIT, with rdataN taken directly from readData.
//   rdataN then holds that value until the next rvalidN.
//
// Configuration
//   DMEM_ARB_FIXED_PRIO_EN  defined   : fixed priority, port 0 wins ties and
//                                       no pointer register is built.
//                           undefined : round-robin. On a tie, the port not
//                                       granted last wins. The pointer moves
//                                       only on a grant.
//
// Ports
//   clk                 in   single clock, rising edge
//   reset               in   asynchronous, active-low reset
//   req0/req1           in   access requests
//   we0/we1             in   1 = write, 0 = read
//   addr0/addr1         in   word addresses   [ADDRW-1:0]
//   wdata0/wdata1       in   write data       [DATAW-1:0]
//   gnt0/gnt1           out  one-cycle grant pulse (ISSUE)
//   rvalid0/rvalid1     out  one-cycle read-data-valid pulse (WAIT)
//   rdata0/rdata1       out  read data per requester
//   busy                out  high in any state other than IDLE
//   memRead/memWrite    out  memory strobes, only ever high in ISSUE
//   address             out  memory address (holds last latched value)
//   writeData           out  memory write data (holds last latched value)
//   readData            in   memory read data, valid one cycle after memRead
//   state_dbg           out  current FSM state encoding (debug visibility)
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
  parameter int ADDRW = 5,
  parameter int DATAW = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [ADDRW-1:0] addr0,
  input  logic [ADDRW-1:0] addr1,
  input  logic [DATAW-1:0] wdata0,
  input  logic [DATAW-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [DATAW-1:0] rdata0,
  output logic [DATAW-1:0] rdata1,
  output logic             busy,
  output logic             memRead,
  output logic             memWrite,
  output logic [ADDRW-1:0] address,
  output logic [DATAW-1:0] writeData,
  input  logic [DATAW-1:0] readData,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               winner_q, winner_d;   // 0 = port 0, 1 = port 1
  logic               we_q, we_d;
  logic [ADDRW-1:0]   addr_q, addr_d;
  logic [DATAW-1:0]   wdata_q, wdata_d;
  logic [DATAW-1:0]   rdata0_q, rdata0_d;
  logic [DATAW-1:0]   rdata1_q, rdata1_d;
  logic               arb_win;              // port that wins this IDLE cycle

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef DMEM_ARB_FIXED_PRIO_EN
  // Port 0 always wins. Port 1 wins only when it requests alone.
  assign arb_win = ~req0;
`else
  logic last_q, last_d;                     // id granted most recently

  always_comb begin
    arb_win = 1'b0;
    if (req0 && req1) begin
      // On a tie, the port that was not granted last wins.
      arb_win = ~last_q;
    end else begin
      // A lone requester wins regardless of the pointer.
      arb_win = ~req0;
    end
  end

  // The pointer moves only when a grant is actually issued.
  always_comb begin
    last_d = last_q;
    if (state_q == ISSUE) begin
      last_d = winner_q;
    end
  end

  // Reset value 1 makes port 0 the first tie winner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM next state and transaction latch
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          winner_d = arb_win;
          we_d     = arb_win ? we1    : we0;
          addr_d   = arb_win ? addr1  : addr0;
          wdata_d  = arb_win ? wdata1 : wdata0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // A write finishes at the edge that ends ISSUE. A read still needs
        // the registered memory output, so it waits one more cycle.
        state_d = we_q ? IDLE : WAIT;
      end
      WAIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    rvalid0  = 1'b0;
    rvalid1  = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    if (state_q == ISSUE) begin
      gnt0     = ~winner_q;
      gnt1     = winner_q;
      memWrite = we_q;
      memRead  = ~we_q;
    end
    if (state_q == WAIT) begin
      rvalid0 = ~winner_q;
      rvalid1 = winner_q;
    end
  end

  // Read data passes straight through during the valid pulse and is captured
  // there. This lets rdataN hold its value between pulses.
  always_comb begin
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (rvalid0) begin
      rdata0_d = readData;
    end
    if (rvalid1) begin
      rdata1_d = readData;
    end
  end

  assign rdata0    = rdata0_d;
  assign rdata1    = rdata1_d;
  assign address   = addr_q;
  assign writeData = wdata_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // An asynchronous reset drops any in-flight transaction. The state returns
  // to IDLE, so no grant or valid can follow for it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      winner_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Structural properties
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_strobe_excl : assert property (@(posedge clk) disable iff (!reset)
    !(memRead && memWrite));
  a_gnt_excl    : assert property (@(posedge clk) disable iff (!reset)
    !(gnt0 && gnt1));
  a_rvalid_excl : assert property (@(posedge clk) disable iff (!reset)
    !(rvalid0 && rvalid1));
`endif

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
- REQ-001 Parameter ADDRW, default 5, address width of the shared data memory.
- REQ-002 Parameter DATAW, default 32, data width of the shared data memory.
- REQ-003 clk  input  1  single clock; all state updates on rising edge.
- REQ-004 reset  input  1  asynchronous, active-low reset (low = in reset).
- REQ-005 req0 / req1  input  1 each  requester 0 (core) / requester 1 (loader/DMA) access request.
- REQ-006 we0 / we1  input  1 each  1 = write, 0 = read, qualified by reqN.
- REQ-007 addr0 / addr1  input  ADDRW each  word address.
- REQ-008 wdata0 / wdata1  input  DATAW each  write data.
- REQ-009 gnt0 / gnt1  output  1 each  one-cycle pulse: request N accepted and issued to memory.
- REQ-010 rvalid0 / rvalid1  output  1 each  one-cycle pulse: rdataN valid.
- REQ-011 rdata0 / rdata1  output  DATAW each  read data returned to requester N.
- REQ-012 busy  output  1  high in any state other than IDLE.
- REQ-013 memRead / memWrite  output  1 each  memory strobes.
- REQ-014 address  output  ADDRW  memory address; writeData  output  DATAW  memory write data.
- REQ-015 readData  input  DATAW  memory read data, registered in memory, valid one cycle after memRead.

Function
- REQ-016 FSM states IDLE, ISSUE, WAIT; one transaction in flight at a time.
- REQ-017 IDLE: if req0 or req1 high, latch winner id, we, addr, wdata and go to ISSUE; else stay in IDLE.
- REQ-018 ISSUE: drive address/writeData from latched values, memWrite = latched we, memRead = !latched we, pulse gnt of winner; next state WAIT for a read, IDLE for a write.
- REQ-019 WAIT: pulse rvalid of winner, rdata of winner = readData; next state IDLE.
- REQ-020 Latency: write req sampled in IDLE at edge N -> gnt at cycle N+1 -> memory written at edge N+2; read -> gnt at cycle N+1 -> rvalid at cycle N+2.
- REQ-021 Requester holds reqN/weN/addrN/wdataN until gntN; deasserting reqN after the IDLE sample does not cancel the latched transaction.
- REQ-022 Arbitration: round-robin; the requester not granted last wins when both request in the same IDLE cycle; a lone requester wins regardless of pointer.
- REQ-023 Pointer updates only on a grant, to the granted id.
- REQ-024 A requester holding req high through its own gnt is re-arbitrated in the next IDLE cycle (no back-to-back issue without IDLE).
- REQ-025 memRead and memWrite are never high together; both are 0 outside ISSUE.
- REQ-026 gnt0/gnt1 and rvalid0/rvalid1 are mutually exclusive; rdataN holds last returned value between rvalid pulses.
- REQ-027 address/writeData hold last latched values outside ISSUE.

Reset
- REQ-028 While reset is low: state = IDLE, pointer = last granted 1 (port 0 wins first tie), gnt*, rvalid*, busy, memRead, memWrite = 0, address, writeData, rdata0, rdata1 = 0.
- REQ-029 Reset asserted in ISSUE or WAIT aborts the transaction; no gnt/rvalid is emitted for it after release.
- REQ-030 First arbitration occurs in the first IDLE cycle after reset deassertion.

Configuration
- REQ-031 Macro DMEM_ARB_FIXED_PRIO_EN defined: fixed priority, requester 0 always wins ties, pointer not implemented.
- REQ-032 Macro DMEM_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-022/REQ-023.

Verification
- REQ-033 req0 write addr 5, data 0xDEADBEEF -> gnt0 at cycle N+1 with memWrite = 1, address = 5; then req0 read addr 5 -> rvalid0 two cycles after sample, rdata0 = 0xDEADBEEF.
- REQ-034 req0 and req1 both read (addr 1, addr 2), held high for 6 cycles after reset -> grants alternate gnt0, gnt1 (round-robin); with DMEM_ARB_FIXED_PRIO_EN, gnt0 on every grant.
- REQ-035 req1 alone write addr 31, data 0x12345678 -> gnt1 only, memRead = 0 throughout, busy high for 1 cycle.
- REQ-036 Reset pulled low during WAIT of a req1 read -> all outputs 0, no rvalid1 after release, next req0 read granted first.
- REQ-037 req0 dropped the cycle after IDLE sample of a read addr 3 -> transaction still completes, rvalid0 asserted with memory word 3.
- REQ-038 Continuous random traffic on both ports -> memRead & memWrite never both high, at most one gnt and one rvalid per cycle, scoreboard readback matches.
